// File: rtl/fp_minmax_align.sv
// Delay-aligns FloPoCo operand pairs with the greater_than result and registers max/min/tag.
// Optional: define FP_MINMAX_NAN_EN to add out_nan and NaN-propagating selection.
module fp_minmax_align #(
  parameter int WIDTH = 26,
  parameter int LAT   = 3,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH:0]   inA,
  input  logic [WIDTH:0]   inB,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             greater,
  output logic             out_valid,
  output logic [WIDTH:0]   out_max,
  output logic [WIDTH:0]   out_min,
  output logic             out_a_gt_b,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       inflight
`ifdef FP_MINMAX_NAN_EN
  ,
  output logic             out_nan
`endif
);

  logic             dly_v   [1:LAT];
  logic [WIDTH:0]   dly_a   [1:LAT];
  logic [WIDTH:0]   dly_b   [1:LAT];
  logic [TAG_W-1:0] dly_tag [1:LAT];

  // Fixed-depth shift line; the comparator cannot stall, so neither can we.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= LAT; i++) begin
        dly_v[i]   <= 1'b0;
        dly_a[i]   <= '0;
        dly_b[i]   <= '0;
        dly_tag[i] <= '0;
      end
    end else begin
      dly_v[1]   <= in_valid;
      dly_a[1]   <= inA;
      dly_b[1]   <= inB;
      dly_tag[1] <= in_tag;
      for (int i = 2; i <= LAT; i++) begin
        dly_v[i]   <= dly_v[i-1];
        dly_a[i]   <= dly_a[i-1];
        dly_b[i]   <= dly_b[i-1];
        dly_tag[i] <= dly_tag[i-1];
      end
    end
  end

  logic           last_v;
  logic [WIDTH:0] last_a;
  logic [WIDTH:0] last_b;
  logic [WIDTH:0] sel_max;
  logic [WIDTH:0] sel_min;
  logic           sel_nan;

  assign last_v = dly_v[LAT];
  assign last_a = dly_a[LAT];
  assign last_b = dly_b[LAT];

  always_comb begin
    sel_nan = 1'b0;
    if (greater) begin
      sel_max = last_a;
      sel_min = last_b;
    end else begin
      sel_max = last_b;
      sel_min = last_a;
    end
`ifdef FP_MINMAX_NAN_EN
    // A NaN operand wins both slots so it propagates into the slab reduction.
    if (last_a[WIDTH:WIDTH-1] == 2'b11) begin
      sel_nan = 1'b1;
      sel_max = last_a;
      sel_min = last_a;
    end else if (last_b[WIDTH:WIDTH-1] == 2'b11) begin
      sel_nan = 1'b1;
      sel_max = last_b;
      sel_min = last_b;
    end
`endif
  end

  logic out_nan_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_max    <= '0;
      out_min    <= '0;
      out_a_gt_b <= 1'b0;
      out_tag    <= '0;
      out_nan_q  <= 1'b0;
    end else begin
      out_valid <= last_v;
      if (last_v) begin
        out_max    <= sel_max;
        out_min    <= sel_min;
        out_a_gt_b <= greater;
        out_tag    <= dly_tag[LAT];
        out_nan_q  <= sel_nan;
      end
    end
  end

`ifdef FP_MINMAX_NAN_EN
  assign out_nan = out_nan_q;
`else
  logic unused_nan;
  assign unused_nan = out_nan_q;
`endif

  // A pair stays counted until the cycle its result is presented has ended.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 5'd0;
    end else if (in_valid && !out_valid) begin
      if (inflight != 5'd31) inflight <= inflight + 5'd1;
    end else if (!in_valid && out_valid) begin
      if (inflight != 5'd0) inflight <= inflight - 5'd1;
    end
  end

endmodule
